sdm_rr_scheduler: RTL and testbench

//   Shares one "1010" serial sequence-detector datapath among NCH serial input channels.
//   A round-robin arbiter grants at most one channel bit per cycle.
//   The block keeps a separate 2-bit detector state and a match counter for every channel.
//   It sits between the per-lane serial sources and the status/interrupt logic.

---
 rtl/sdm_rr_scheduler.sv | 128 ++++++++++++
 tb/tb_sdm_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sdm_rr_scheduler
// Brief  : Round-robin sharing of one "1010" detector among NCH serial lanes,
//          with per-lane detector state and saturating match counters.
// Rev    : 1.0  initial release
// ============================================================================
module sdm_rr_scheduler #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         din,
    output logic [NCH-1:0]         gnt,
    output logic                   det_valid,
    output logic [$clog2(NCH)-1:0] det_ch,
    input  logic                   clr_cnt,
    input  logic [$clog2(NCH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]       cnt_out
);
    localparam int               c_iw      = $clog2(NCH);
    localparam logic [c_iw-1:0]  c_last_ch = c_iw'(NCH - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t              r_state [NCH];
    state_t              w_cur;
    state_t              w_nxt;
    logic                w_bit;
    logic                w_detect;
    logic                w_found;
    logic [c_iw-1:0]     r_ptr;
    logic [c_iw-1:0]     w_gidx;
    logic [c_iw-1:0]     w_cand;
    logic [NCH-1:0]      w_onehot;
    logic [NCH*CNT_W-1:0] w_cnt_flat;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int off = 0; off < NCH; off++) begin
            w_cand = c_iw'((int'(r_ptr) + off) % NCH);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    assign w_onehot = w_found ? (NCH'(1) << w_gidx) : '0;
    assign gnt      = reset ? '0 : w_onehot;

    // Next state of the granted lane only; other lanes never enter this logic.
    always_comb begin
        w_cur    = r_state[w_gidx];
        w_bit    = din[w_gidx];
        w_nxt    = w_cur;
        w_detect = 1'b0;
        case (w_cur)
            S0: w_nxt = w_bit ? S1 : S0;
            S1: w_nxt = w_bit ? S1 : S2;
            S2: w_nxt = w_bit ? S3 : S0;
            S3: begin
                w_nxt    = w_bit ? S1 : S2;
                w_detect = !w_bit;
            end
            default: w_nxt = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= S0;
            end
            r_ptr     <= '0;
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            if (w_found) begin
                r_state[w_gidx] <= w_nxt;
                r_ptr           <= (w_gidx == c_last_ch) ? '0 : w_gidx + 1'b1;
            end
            det_valid <= w_found && w_detect;
            if (w_found && w_detect) begin
                det_ch <= w_gidx;
            end
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_cnt
            logic [CNT_W-1:0] r_val;

            // Clear has priority over a coincident increment.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_val <= '0;
                end else if (clr_cnt) begin
                    r_val <= '0;
                end else if (w_onehot[i] && w_detect && (r_val != c_cnt_max)) begin
                    r_val <= r_val + 1'b1;
                end
            end

            assign w_cnt_flat[i*CNT_W +: CNT_W] = r_val;
        end
    endgenerate

    always_comb begin
        cnt_out = '0;
        if (int'(cnt_sel) < NCH) begin
            cnt_out = w_cnt_flat[int'(cnt_sel)*CNT_W +: CNT_W];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_sdm_rr_scheduler
// Brief  : Directed bench for sdm_rr_scheduler (CNT_W=8 and CNT_W=2 instances)
//          checked against a last-four-bits behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sdm_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] din = '0;
    logic [1:0] cnt_sel = '0;

    logic [3:0] gnt1, gnt2;
    logic       dv1, dv2;
    logic [1:0] dch1, dch2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int nvec = 0;
    int nerr = 0;
    bit run  = 1'b0;

    // Model: pointer, last four consumed bits per lane, counters of both widths.
    int         m_ptr;
    logic [3:0] m_hist [4];
    int         m_cnt8 [4];
    int         m_cnt2 [4];
    bit         m_dv;
    int         m_dch;

    sdm_rr_scheduler #(.NCH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt1),
        .det_valid(dv1), .det_ch(dch1), .clr_cnt(clr_cnt),
        .cnt_sel(cnt_sel), .cnt_out(cnt1)
    );

    sdm_rr_scheduler #(.NCH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt2),
        .det_valid(dv2), .det_ch(dch2), .clr_cnt(clr_cnt),
        .cnt_sel(cnt_sel), .cnt_out(cnt2)
    );

    always #5 clk = ~clk;

    function automatic int arb(input logic [3:0] r, input int p);
        for (int o = 0; o < 4; o++) begin
            int k;
            k = (p + o) % 4;
            if (r[k[1:0]]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] v;
        v = '0;
        if (g >= 0) v[g[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0;
        m_dv  = 1'b0;
        m_dch = 0;
        for (int k = 0; k < 4; k++) begin
            m_hist[k] = '0;
            m_cnt8[k] = 0;
            m_cnt2[k] = 0;
        end
    endtask

    // One clock: capture the inputs seen by the edge, then advance the model.
    task automatic tick();
        logic [3:0] r, d;
        logic       c;
        int         g;
        r = req;
        d = din;
        c = clr_cnt;
        @(posedge clk);
        g    = arb(r, m_ptr);
        m_dv = 1'b0;
        if (g >= 0) begin
            m_hist[g] = {m_hist[g][2:0], d[g[1:0]]};
            m_ptr     = (g + 1) % 4;
            if (m_hist[g] == 4'b1010) begin
                m_dv  = 1'b1;
                m_dch = g;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (c) begin
                m_cnt8[k] = 0;
                m_cnt2[k] = 0;
            end else if (m_dv && k == m_dch) begin
                if (m_cnt8[k] < 255) m_cnt8[k]++;
                if (m_cnt2[k] < 3)   m_cnt2[k]++;
            end
        end
        #1;
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic c);
        req     = r;
        din     = d;
        clr_cnt = c;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        req = 4'hF;
        #2;
        check("rst_gnt", gnt1, 4'b0000);
        check("rst_det_valid", dv1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        req     = '0;
        din     = '0;
        clr_cnt = 1'b0;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run) begin
            check("gnt", gnt1, reset ? 4'b0 : onehot(arb(req, m_ptr)));
            check("gnt_w2", gnt2, reset ? 4'b0 : onehot(arb(req, m_ptr)));
            check("det_valid", dv1, m_dv);
            check("det_valid_w2", dv2, m_dv);
            if (m_dv) begin
                check("det_ch", dch1, m_dch);
                check("det_ch_w2", dch2, m_dch);
            end
            check("cnt_out", cnt1, m_cnt8[cnt_sel]);
            check("cnt_out_w2", cnt2, m_cnt2[cnt_sel]);
        end
    end

    logic [8:0] tbl [12] = '{
        9'b0011_0011_0, 9'b0010_0000_0, 9'b0011_0001_0, 9'b1001_1000_0,
        9'b0101_0101_0, 9'b1110_0000_0, 9'b0100_0100_0, 9'b0000_0000_0,
        9'b1111_1111_1, 9'b1010_0000_0, 9'b0001_0001_0, 9'b1100_0100_0
    };

    initial begin
        int pulses;
        int d1, d2, i1, i2;
        logic [3:0] pat;
        logic [3:0] g;

        do_reset();
        run = 1'b1;

        // T1: single lane, one match.
        cnt_sel = 2'd0;
        cyc(4'b0001, 4'b0001, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0001, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0);
        check("t1_det_valid", dv1, 1'b1);
        check("t1_det_ch", dch1, 2'd0);
        check("t1_cnt0", cnt1, 8'd1);
        cyc(4'b0000, 4'b0000, 1'b0);
        check("t1_pulse_end", dv1, 1'b0);

        // T2: overlapping matches.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0001, {3'b000, ~i[0]}, 1'b0);
            if (dv1) pulses++;
        end
        check("t2_pulses", pulses, 2);
        check("t2_cnt0", cnt1, 8'd2);

        // T3: all lanes requesting rotate in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = 4'hF;
            din = '0;
            #1;
            check("t3_gnt", gnt1, 4'b0001 << (i % 4));
            tick();
        end

        // T4: lanes 1 and 2 interleaved, each source advances only on consumption.
        do_reset();
        pat = 4'b0101;
        i1 = 0; i2 = 0; d1 = 0; d2 = 0;
        for (int c = 0; c < 20 && (i1 < 4 || i2 < 4); c++) begin
            req    = {1'b0, i2 < 4, i1 < 4, 1'b0};
            din    = '0;
            din[1] = (i1 < 4) ? pat[i1[1:0]] : 1'b0;
            din[2] = (i2 < 4) ? pat[i2[1:0]] : 1'b0;
            #1;
            g = gnt1;
            tick();
            if (g[1]) i1++;
            if (g[2]) i2++;
            if (dv1 && dch1 == 2'd1) d1++;
            if (dv1 && dch1 == 2'd2) d2++;
            if (dv1 && dch1 != 2'd1 && dch1 != 2'd2) d1 += 10;
        end
        check("t4_lane1_done", i1, 4);
        check("t4_lane2_done", i2, 4);
        check("t4_det_ch1", d1, 1);
        check("t4_det_ch2", d2, 1);

        // T5: lane 3, five matches; narrow counter saturates; clear beats increment.
        do_reset();
        cnt_sel = 2'd3;
        for (int i = 0; i < 12; i++) begin
            cyc(4'b1000, {~i[0], 3'b000}, 1'b0);
        end
        check("t5_cnt_w2_sat", cnt2, 2'd3);
        check("t5_cnt_w8", cnt1, 8'd5);
        cyc(4'b1000, 4'b1000, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b1);
        check("t5_clr_det_valid", dv2, 1'b1);
        check("t5_clr_cnt_w2", cnt2, 2'd0);
        check("t5_clr_cnt_w8", cnt1, 8'd0);

        // T6: reset in the middle of a partial sequence.
        do_reset();
        cnt_sel = 2'd0;
        cyc(4'b0001, 4'b0001, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0);
        cyc(4'b0001, 4'b0001, 1'b0);
        do_reset();
        req = 4'hF;
        #1;
        check("t6_ptr_zero", gnt1, 4'b0001);
        cyc(4'b0001, 4'b0000, 1'b0);
        check("t6_no_det", dv1, 1'b0);
        check("t6_cnt0", cnt1, 8'd0);

        // Mixed request patterns, dropped requests, and a clear.
        for (int i = 0; i < 12; i++) begin
            cnt_sel = i[1:0];
            cyc(tbl[i][8:5], tbl[i][4:1], tbl[i][0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
